// File: rtl/puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// puf_eval_ctrl
// Sequencer for a 16-challenge / 16-response arbiter PUF array. A challenge is
// accepted over a valid/ready request port and applied to the array. The block
// then fires NUM_EVAL race pulses, samples the response after each pulse has
// settled, majority-votes every response bit, and returns the voted word plus a
// per-bit instability mask over a valid/ready response port.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake; req_ready is high only in IDLE
//   req_challenge[15:0]        challenge, captured on the request handshake
//   puf_challenge[15:0]        challenge held on the array until the next request
//   puf_pulse                  registered race-launch pulse
//   puf_response[15:0]         array response, sampled at the end of SETTLE
//   rsp_valid / rsp_ready      response handshake
//   rsp_data[15:0]             majority-voted response
//   rsp_unstable[15:0]         bit i set when the evaluations of bit i disagreed
//   busy                       high in every state except IDLE
// -----------------------------------------------------------------------------
module puf_eval_ctrl #(
    parameter int NUM_EVAL    = 5,
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_CYC   = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_challenge,
    output logic [15:0] puf_challenge,
    output logic        puf_pulse,
    input  logic [15:0] puf_response,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_unstable,
    output logic        busy
);

    localparam int CW    = $clog2(NUM_EVAL + 1);
    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B = (SETTLE_CYC > RECOVER_CYC) ? SETTLE_CYC : RECOVER_CYC;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // The timer counts down from (phase length - 1) to zero.
    localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] SETUP_LD   = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD   = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] RECOVER_LD = TW'(RECOVER_CYC - 1);
    localparam logic [CW-1:0] N_EVAL     = CW'(NUM_EVAL);
    localparam logic [CW-1:0] HALF_EVAL  = CW'(NUM_EVAL / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_FIRE    = 3'd2,
        S_SETTLE  = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [CW-1:0]   eval_cnt_q, eval_cnt_d;
    logic [CW-1:0]   ones_cnt_q [16];
    logic [CW-1:0]   ones_cnt_d [16];
    logic [15:0]     chal_q, chal_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     rsp_unst_q, rsp_unst_d;
    logic            pulse_q, pulse_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;

    logic            accept_s;
    logic            sample_s;
    logic            finish_s;

    assign accept_s = (state_q == S_IDLE) && req_valid && req_ready_q;
    assign sample_s = (state_q == S_SETTLE) && (tmr_q == {TW{1'b0}});
    assign finish_s = (state_q == S_RECOVER) && (tmr_q == {TW{1'b0}}) &&
                      (eval_cnt_q >= N_EVAL);

    // State, phase timer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= {TW{1'b0}};
            eval_cnt_q <= {CW{1'b0}};
            chal_q     <= 16'h0000;
            rsp_data_q <= 16'h0000;
            rsp_unst_q <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                ones_cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            eval_cnt_q <= eval_cnt_d;
            chal_q     <= chal_d;
            rsp_data_q <= rsp_data_d;
            rsp_unst_q <= rsp_unst_d;
            for (int i = 0; i < 16; i++) begin
                ones_cnt_q[i] <= ones_cnt_d[i];
            end
        end
    end

    // Next-state and phase-timer logic; the timer reloads on every state entry.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_SETUP;
                    tmr_d   = SETUP_LD;
                end else begin
                    tmr_d   = {TW{1'b0}};
                end
            end
            S_SETUP: begin
                if (tmr_q == {TW{1'b0}}) begin
                    state_d = S_FIRE;
                    tmr_d   = PULSE_LD;
                end else begin
                    tmr_d   = tmr_q - TW'(1);
                end
            end
            S_FIRE: begin
                if (tmr_q == {TW{1'b0}}) begin
                    state_d = S_SETTLE;
                    tmr_d   = SETTLE_LD;
                end else begin
                    tmr_d   = tmr_q - TW'(1);
                end
            end
            S_SETTLE: begin
                if (tmr_q == {TW{1'b0}}) begin
                    state_d = S_RECOVER;
                    tmr_d   = RECOVER_LD;
                end else begin
                    tmr_d   = tmr_q - TW'(1);
                end
            end
            S_RECOVER: begin
                if (tmr_q != {TW{1'b0}}) begin
                    tmr_d   = tmr_q - TW'(1);
                end else if (finish_s) begin
                    state_d = S_DONE;
                    tmr_d   = {TW{1'b0}};
                end else begin
                    state_d = S_FIRE;
                    tmr_d   = PULSE_LD;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = {TW{1'b0}};
            end
        endcase
    end

    // Challenge capture, ones counting and the majority vote on DONE entry.
    always_comb begin
        chal_d     = chal_q;
        eval_cnt_d = eval_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_unst_d = rsp_unst_q;
        for (int i = 0; i < 16; i++) begin
            ones_cnt_d[i] = ones_cnt_q[i];
        end
        if (accept_s) begin
            chal_d     = req_challenge;
            eval_cnt_d = {CW{1'b0}};
            for (int i = 0; i < 16; i++) begin
                ones_cnt_d[i] = {CW{1'b0}};
            end
        end else if (sample_s) begin
            // Counters cannot wrap: at most NUM_EVAL samples per request.
            eval_cnt_d = eval_cnt_q + CW'(1);
            for (int i = 0; i < 16; i++) begin
                ones_cnt_d[i] = ones_cnt_q[i] + CW'(puf_response[i]);
            end
        end else if (finish_s) begin
            for (int i = 0; i < 16; i++) begin
                rsp_data_d[i] = (ones_cnt_q[i] > HALF_EVAL);
                rsp_unst_d[i] = (ones_cnt_q[i] != {CW{1'b0}}) &&
                                (ones_cnt_q[i] != N_EVAL);
            end
        end else begin
            chal_d = chal_q;
        end
    end

    // Output decode from the next state so every output is a clean flop.
    always_comb begin
        pulse_d     = (state_d == S_FIRE);
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // Registered handshake and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pulse_q     <= pulse_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign puf_challenge = chal_q;
    assign puf_pulse     = pulse_q;
    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_unstable  = rsp_unst_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_eval_ctrl
// Two controllers share clock, reset and data inputs: instance A uses default
// parameters, instance B uses NUM_EVAL=1 with every phase one cycle long. Only
// the instance picked by sel sees req_valid. A reference vote computed from the
// sample list the bench itself fed in gives the expected response words.
// -----------------------------------------------------------------------------
module tb_puf_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_challenge = 16'h0000;
    logic [15:0] puf_response = 16'h0000;
    logic        rsp_ready = 1'b0;

    logic        a_req_ready, a_puf_pulse, a_rsp_valid, a_busy;
    logic [15:0] a_puf_challenge, a_rsp_data, a_rsp_unstable;
    logic        b_req_ready, b_puf_pulse, b_rsp_valid, b_busy;
    logic [15:0] b_puf_challenge, b_rsp_data, b_rsp_unstable;
    logic        a_req_valid, b_req_valid;

    logic        s_req_ready, s_puf_pulse, s_rsp_valid, s_busy;
    logic [15:0] s_puf_challenge, s_rsp_data, s_rsp_unstable;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] smp [15];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;

    assign s_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign s_puf_pulse     = sel ? b_puf_pulse     : a_puf_pulse;
    assign s_rsp_valid     = sel ? b_rsp_valid     : a_rsp_valid;
    assign s_busy          = sel ? b_busy          : a_busy;
    assign s_puf_challenge = sel ? b_puf_challenge : a_puf_challenge;
    assign s_rsp_data      = sel ? b_rsp_data      : a_rsp_data;
    assign s_rsp_unstable  = sel ? b_rsp_unstable  : a_rsp_unstable;

    puf_eval_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_challenge(req_challenge),
        .puf_challenge(a_puf_challenge), .puf_pulse(a_puf_pulse), .puf_response(puf_response),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
        .rsp_unstable(a_rsp_unstable), .busy(a_busy)
    );

    puf_eval_ctrl #(
        .NUM_EVAL(1), .SETUP_CYC(1), .PULSE_CYC(1), .SETTLE_CYC(1), .RECOVER_CYC(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_challenge(req_challenge),
        .puf_challenge(b_puf_challenge), .puf_pulse(b_puf_pulse), .puf_response(puf_response),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
        .rsp_unstable(b_rsp_unstable), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Majority vote over the first n samples, bit by bit.
    task automatic ref_vote(input int n, output logic [15:0] d, output logic [15:0] u);
        int cnt;
        for (int b = 0; b < 16; b++) begin
            cnt = 0;
            for (int e = 0; e < n; e++) cnt += int'(smp[e][b]);
            d[b] = (cnt > n / 2);
            u[b] = (cnt != 0) && (cnt != n);
        end
    endtask

    // One full request on the selected instance. Call and return at a negedge
    // in IDLE. hold<0: rsp_ready high all along; hold>=0: ready raised after
    // hold cycles of rsp_valid. noise keeps req_valid high with a changing
    // challenge while the controller is busy.
    task automatic run_eval(input logic [15:0] chal, input int hold, input bit noise);
        int ne, pc, lat, n, pulses, w;
        bit w_ok, chal_ok, busy_ok, stable_ok;
        logic [15:0] ed, eu;
        ne  = sel ? 1 : 5;
        pc  = sel ? 1 : 2;
        // Edges from the accepting edge to rsp_valid: SETUP + NUM_EVAL*(P+S+R).
        // As cycle numbers this is k+1+that (k+45 for A, k+5 for B).
        lat = sel ? (1 + 1 * 3) : (4 + 5 * (2 + 4 + 2));
        ref_vote(ne, ed, eu);
        check_eq("idle_req_ready", {31'd0, s_req_ready}, 32'd1);
        req_challenge = chal;
        req_valid     = 1'b1;
        rsp_ready     = (hold < 0);
        @(posedge clk);
        n = 0; pulses = 0; w = 0;
        w_ok = 1'b1; chal_ok = 1'b1; busy_ok = 1'b1; stable_ok = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            if (noise) req_challenge = 16'($urandom);
            else       req_valid     = 1'b0;
            if (s_puf_challenge !== chal) chal_ok = 1'b0;
            if (s_req_ready !== 1'b0 || s_busy !== 1'b1) busy_ok = 1'b0;
            if (s_puf_pulse) begin
                if (w == 0) begin
                    pulses++;
                    if (pulses <= ne) puf_response = smp[pulses-1];
                end
                w++;
            end else begin
                if (w != 0 && w != pc) w_ok = 1'b0;
                w = 0;
            end
            if (s_rsp_valid) break;
            @(posedge clk);
            n++;
        end
        check_eq("latency", 32'(n), 32'(lat));
        check_eq("pulse_count", 32'(pulses), 32'(ne));
        check_eq("pulse_width", {31'd0, w_ok}, 32'd1);
        check_eq("chal_held", {31'd0, chal_ok}, 32'd1);
        check_eq("busy_not_ready", {31'd0, busy_ok}, 32'd1);
        check_eq("rsp_data", {16'd0, s_rsp_data}, {16'd0, ed});
        check_eq("rsp_unstable", {16'd0, s_rsp_unstable}, {16'd0, eu});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (s_rsp_valid !== 1'b1 || s_rsp_data !== ed || s_rsp_unstable !== eu ||
                    s_req_ready !== 1'b0) stable_ok = 1'b0;
            end
            check_eq("backpressure_hold", {31'd0, stable_ok}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_valid", {31'd0, s_rsp_valid}, 32'd0);
        check_eq("post_req_ready", {31'd0, s_req_ready}, 32'd1);
        check_eq("post_busy", {31'd0, s_busy}, 32'd0);
        check_eq("chal_kept", {16'd0, s_puf_challenge}, {16'd0, chal});
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic rand_samples(input int n);
        logic [15:0] base;
        base = 16'($urandom);
        for (int e = 0; e < n; e++) smp[e] = base ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
    endtask

    initial begin
        bit fired, quiet;
        int hold;
        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_pulse", {31'd0, a_puf_pulse}, 32'd0);
        check_eq("rst_valid", {31'd0, a_rsp_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("rst_chal", {16'd0, a_puf_challenge}, 32'd0);
        check_eq("rst_data", {a_rsp_data, a_rsp_unstable}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", {31'd0, a_req_ready}, 32'd1);

        // Stable PUF, fixed challenge.
        for (int e = 0; e < 5; e++) smp[e] = 16'hA5C3;
        run_eval(16'h1234, 0, 1'b0);

        // Flaky bits 0 and 15.
        smp[0] = 16'h0001; smp[1] = 16'h8000; smp[2] = 16'h0001;
        smp[3] = 16'h0000; smp[4] = 16'h0001;
        run_eval(16'h0F0F, 0, 1'b0);

        // Backpressure for 10 cycles.
        rand_samples(5);
        run_eval(16'($urandom), 10, 1'b0);

        // Request held high with a changing challenge while busy.
        rand_samples(5);
        run_eval(16'hBEEF, 2, 1'b1);

        // Reset asserted in the middle of a pulse.
        req_challenge = 16'h5A5A;
        req_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) begin
            if (a_puf_pulse) fired = 1'b1;
            else @(negedge clk);
        end
        check_eq("t1_fire_reached", {31'd0, fired}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t1_pulse", {31'd0, a_puf_pulse}, 32'd0);
        check_eq("t1_valid", {31'd0, a_rsp_valid}, 32'd0);
        check_eq("t1_busy", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t1_req_ready", {31'd0, a_req_ready}, 32'd1);
        check_eq("t1_chal", {16'd0, a_puf_challenge}, 32'd0);
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0) quiet = 1'b0;
        end
        check_eq("t1_no_response", {31'd0, quiet}, 32'd1);

        // Randomized runs on the default instance.
        for (int r = 0; r < 6; r++) begin
            rand_samples(5);
            hold = int'($urandom_range(0, 4)) - 1;
            run_eval(16'($urandom), hold, 1'($urandom));
        end

        // Single-evaluation, one-cycle-phase instance.
        sel = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            rand_samples(1);
            hold = int'($urandom_range(0, 3)) - 1;
            run_eval(16'($urandom), hold, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
